// File: rtl/contador_ctrl_pkg.sv
// Shared types for the counter run-control sequencer: FSM encoding, mode
// constants, command decode and the registered status flags.
package contador_ctrl_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned CMD_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   typedef enum logic [CMD_W-1:0] {
      CMD_NONE  = 2'd0,
      CMD_STOP  = 2'd1,
      CMD_START = 2'd2,
      CMD_PAUSE = 2'd3
   } cmd_t;

   typedef struct packed {
      logic busy;
      logic paused;
      logic done;
      logic wrap;
   } status_t;

   // Resolve simultaneous controls: stop beats start beats pause.
   function automatic cmd_t decode_cmd(input logic stop, input logic start, input logic pause);
      cmd_t cmd;
      if (stop)
         cmd = CMD_STOP;
      else if (start)
         cmd = CMD_START;
      else if (pause)
         cmd = CMD_PAUSE;
      else
         cmd = CMD_NONE;
      return cmd;
   endfunction

   function automatic logic is_active(input state_t s);
      return (s == ST_RUN) || (s == ST_PAUSE);
   endfunction

endpackage

// File: rtl/contador_en.sv
// WIDTH-bit up counter with synchronous clear (dominant) and count enable.
module contador_en #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iClr,
   input  logic             iEn,
   output logic [WIDTH-1:0] oCuenta
);

   logic [WIDTH-1:0] r_cuenta;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n)
         r_cuenta <= '0;
      else if (iClr)
         r_cuenta <= '0;
      else if (iEn)
         r_cuenta <= r_cuenta + WIDTH'(1);
   end

   assign oCuenta = r_cuenta;

endmodule

// File: rtl/contador_ctrl.sv
// Run-control sequencer: start/stop/pause, prescaled count enable, terminal
// detection with one-shot or auto-reload operation around contador_en.
module contador_ctrl
   import contador_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 10,
   parameter int unsigned PRESC_W  = 4
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iStart,
   input  logic             iStop,
   input  logic             iPause,
   input  logic             iMode,
   input  logic [WIDTH-1:0] iTerminal,
   output logic [WIDTH-1:0] oCuenta,
   output logic             oBusy,
   output logic             oPaused,
   output logic             oDone,
   output logic             oWrap
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] w_presc_nxt;
   logic [WIDTH-1:0]   r_term;
   logic               r_mode;
   status_t            r_status;
   status_t            w_status_nxt;
   cmd_t               w_cmd;
   logic               w_clr;
   logic               w_en;
   logic               w_latch;
   logic               w_term_hit;
   logic [WIDTH-1:0]   w_cuenta;

   assign w_cmd      = decode_cmd(iStop, iStart, iPause);
   assign w_term_hit = (w_cuenta == r_term);

   // State register
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state, prescaler update, counter controls and next status flags
   always_comb begin
      w_state_nxt  = r_state;
      w_presc_nxt  = r_presc;
      w_clr        = 1'b0;
      w_en         = 1'b0;
      w_latch      = 1'b0;
      w_status_nxt = '0;

      case (w_cmd)
         CMD_STOP: begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
         end
         CMD_START: begin
            w_state_nxt = ST_RUN;
            w_presc_nxt = '0;
            w_clr       = 1'b1;
            w_latch     = 1'b1;
         end
         default: begin
            case (r_state)
               ST_RUN: begin
                  if (w_cmd == CMD_PAUSE) begin
                     w_state_nxt = ST_PAUSE;
                  end else if (r_presc == PRESC_MAX) begin
                     w_presc_nxt = '0;
                     if (!w_term_hit) begin
                        w_en = 1'b1;
                     end else if (r_mode == MODE_PERIODIC) begin
                        w_clr             = 1'b1;
                        w_status_nxt.wrap = 1'b1;
                     end else begin
                        // One-shot: count stays parked on the terminal value
                        w_state_nxt       = ST_DONE;
                        w_status_nxt.done = 1'b1;
                     end
                  end else begin
                     w_presc_nxt = r_presc + PRESC_W'(1);
                  end
               end
               ST_PAUSE: begin
                  if (w_cmd != CMD_PAUSE)
                     w_state_nxt = ST_RUN;
               end
               default: begin
               end
            endcase
         end
      endcase

      w_status_nxt.busy   = is_active(w_state_nxt);
      w_status_nxt.paused = (w_state_nxt == ST_PAUSE);
   end

   // Prescaler, latched run parameters and registered status
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_presc  <= '0;
         r_term   <= '1;
         r_mode   <= MODE_ONESHOT;
         r_status <= '0;
      end else begin
         r_presc  <= w_presc_nxt;
         r_status <= w_status_nxt;
         if (w_latch) begin
            r_term <= iTerminal;
            r_mode <= iMode;
         end
      end
   end

   contador_en #(
      .WIDTH (WIDTH)
   ) u_contador_en (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iClr    (w_clr),
      .iEn     (w_en),
      .oCuenta (w_cuenta)
   );

   assign oCuenta = w_cuenta;
   assign oBusy   = r_status.busy;
   assign oPaused = r_status.paused;
   assign oDone   = r_status.done;
   assign oWrap   = r_status.wrap;

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl: four instances (PRESCALE 1..4) share stimulus and
// are compared each cycle against an elapsed-time reference model.
module tb_contador_ctrl;

   localparam int unsigned W    = 4;
   localparam int          NDUT = 4;
   localparam int          PS [NDUT] = '{1, 2, 3, 4};

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         stop  = 1'b0;
   logic         pause = 1'b0;
   logic         mode  = 1'b0;
   logic [W-1:0] term  = '0;

   logic [W-1:0] o_cnt    [NDUT];
   logic         o_busy   [NDUT];
   logic         o_paused [NDUT];
   logic         o_done   [NDUT];
   logic         o_wrap   [NDUT];

   always #5 clk = ~clk;

   contador_ctrl #(.WIDTH(W), .PRESCALE(1), .PRESC_W(4)) u_p1 (
      .iClk(clk), .iRst_n(rst_n), .iStart(start), .iStop(stop), .iPause(pause),
      .iMode(mode), .iTerminal(term), .oCuenta(o_cnt[0]), .oBusy(o_busy[0]),
      .oPaused(o_paused[0]), .oDone(o_done[0]), .oWrap(o_wrap[0]));
   contador_ctrl #(.WIDTH(W), .PRESCALE(2), .PRESC_W(4)) u_p2 (
      .iClk(clk), .iRst_n(rst_n), .iStart(start), .iStop(stop), .iPause(pause),
      .iMode(mode), .iTerminal(term), .oCuenta(o_cnt[1]), .oBusy(o_busy[1]),
      .oPaused(o_paused[1]), .oDone(o_done[1]), .oWrap(o_wrap[1]));
   contador_ctrl #(.WIDTH(W), .PRESCALE(3), .PRESC_W(4)) u_p3 (
      .iClk(clk), .iRst_n(rst_n), .iStart(start), .iStop(stop), .iPause(pause),
      .iMode(mode), .iTerminal(term), .oCuenta(o_cnt[2]), .oBusy(o_busy[2]),
      .oPaused(o_paused[2]), .oDone(o_done[2]), .oWrap(o_wrap[2]));
   contador_ctrl #(.WIDTH(W), .PRESCALE(4), .PRESC_W(4)) u_p4 (
      .iClk(clk), .iRst_n(rst_n), .iStart(start), .iStop(stop), .iPause(pause),
      .iMode(mode), .iTerminal(term), .oCuenta(o_cnt[3]), .oBusy(o_busy[3]),
      .oPaused(o_paused[3]), .oDone(o_done[3]), .oWrap(o_wrap[3]));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: progress is tracked as elapsed RUN cycles since start
   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
   mst_t m_st   [NDUT];
   int   m_el   [NDUT];
   int   m_cnt  [NDUT];
   int   m_term [NDUT];
   int   m_mode [NDUT];
   bit   m_done [NDUT];
   bit   m_wrap [NDUT];

   task automatic model_reset();
      for (int i = 0; i < NDUT; i++) begin
         m_st[i] = M_IDLE; m_el[i] = 0; m_cnt[i] = 0;
         m_term[i] = 15; m_mode[i] = 0; m_done[i] = 0; m_wrap[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NDUT; i++) begin
         int per;
         m_done[i] = 0;
         m_wrap[i] = 0;
         if (stop) begin
            m_st[i] = M_IDLE;
         end else if (start) begin
            m_st[i] = M_RUN; m_el[i] = 0; m_cnt[i] = 0;
            m_term[i] = int'(term); m_mode[i] = int'(mode);
         end else if (m_st[i] == M_RUN && pause) begin
            m_st[i] = M_PAUSE;
         end else if (m_st[i] == M_PAUSE && !pause) begin
            m_st[i] = M_RUN;
         end else if (m_st[i] == M_RUN) begin
            m_el[i]++;
            per = (m_term[i] + 1) * PS[i];
            if (m_mode[i] == 1) begin
               if (m_el[i] == per) begin
                  m_el[i] = 0;
                  m_wrap[i] = 1;
               end
               m_cnt[i] = m_el[i] / PS[i];
            end else if (m_el[i] == per) begin
               m_st[i] = M_DONE; m_done[i] = 1; m_cnt[i] = m_term[i];
            end else begin
               m_cnt[i] = m_el[i] / PS[i];
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NDUT; i++) begin
         logic [15:0] got, exp;
         got = {8'd0, o_cnt[i], o_busy[i], o_paused[i], o_done[i], o_wrap[i]};
         exp = {8'd0, 4'(m_cnt[i]), m_st[i] == M_RUN || m_st[i] == M_PAUSE,
                m_st[i] == M_PAUSE, m_done[i], m_wrap[i]};
         chk($sformatf("model_P%0d {cnt,busy,paused,done,wrap}", PS[i]), got, exp);
      end
   endtask

   task automatic drive(input logic s, input logic sp, input logic pa, input logic md,
                        input logic [W-1:0] t);
      start = s; stop = sp; pause = pa; mode = md; term = t;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare_all();
      @(negedge clk) rst_n = 1'b1;
   endtask

   typedef struct {
      logic         s, sp, pa, md;
      logic [W-1:0] t;
      logic [W-1:0] e_cnt;
      logic         e_busy, e_done;
   } vec_t;
   vec_t tbl [11];

   initial begin
      // PRESCALE=2 one-shot to terminal 3; mode/terminal changes mid-run ignored
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd1, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd1, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0};

      model_reset();
      #3 compare_all();
      chk("reset_term_default_busy", {15'd0, o_busy[0]}, 16'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int k = 0; k < 11; k++) begin
         drive(tbl[k].s, tbl[k].sp, tbl[k].pa, tbl[k].md, tbl[k].t);
         step();
         chk($sformatf("tbl%0d_cnt", k),  {12'd0, o_cnt[1]}, {12'd0, tbl[k].e_cnt});
         chk($sformatf("tbl%0d_busy", k), {15'd0, o_busy[1]}, {15'd0, tbl[k].e_busy});
         chk($sformatf("tbl%0d_done", k), {15'd0, o_done[1]}, {15'd0, tbl[k].e_done});
      end

      // Periodic PRESCALE=1 terminal 2; terminal input moves to 7 mid-run
      drive(1, 0, 0, 1, 4'd2);
      step();
      chk("per_start_cnt", {12'd0, o_cnt[0]}, 16'd0);
      for (int k = 1; k <= 7; k++) begin
         drive(0, 0, 0, 0, (k >= 2) ? 4'd7 : 4'd2);
         step();
         chk($sformatf("per_cnt_e%0d", k),  {12'd0, o_cnt[0]}, 16'(k % 3));
         chk($sformatf("per_wrap_e%0d", k), {15'd0, o_wrap[0]}, 16'(k % 3 == 0));
      end

      // Asynchronous reset mid-run at count 5, then a normal start
      drive(1, 0, 0, 1, 4'd15);
      step();
      drive(0, 0, 0, 0, 4'd15);
      repeat (5) step();
      chk("pre_reset_cnt", {12'd0, o_cnt[0]}, 16'd5);
      async_reset();
      chk("async_reset_cnt", {12'd0, o_cnt[0]}, 16'd0);
      chk("async_reset_busy", {15'd0, o_busy[0]}, 16'd0);
      drive(1, 0, 0, 0, 4'd4);
      step();
      chk("post_reset_start_busy", {15'd0, o_busy[0]}, 16'd1);

      // Pause for 5 cycles at count 1 / prescaler 1 with PRESCALE=4
      drive(1, 0, 0, 0, 4'd15);
      step();
      drive(0, 0, 0, 0, 4'd15);
      repeat (5) step();
      chk("pause_pre_cnt", {12'd0, o_cnt[3]}, 16'd1);
      drive(0, 0, 1, 0, 4'd15);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("pause_flag_%0d", k), {15'd0, o_paused[3]}, 16'd1);
         chk($sformatf("pause_cnt_%0d", k), {12'd0, o_cnt[3]}, 16'd1);
      end
      drive(0, 0, 0, 0, 4'd15);
      step();
      chk("pause_release_flag", {15'd0, o_paused[3]}, 16'd0);
      repeat (2) step();
      chk("pause_release_cnt_held", {12'd0, o_cnt[3]}, 16'd1);
      step();
      chk("pause_release_cnt_inc", {12'd0, o_cnt[3]}, 16'd2);

      // Stop coinciding with the terminal tick (PRESCALE=2, terminal 1)
      drive(1, 0, 0, 0, 4'd1);
      step();
      drive(0, 0, 0, 0, 4'd1);
      repeat (3) step();
      drive(0, 1, 0, 0, 4'd1);
      step();
      chk("stop_term_cnt", {12'd0, o_cnt[1]}, 16'd1);
      chk("stop_term_busy", {15'd0, o_busy[1]}, 16'd0);
      chk("stop_term_done", {15'd0, o_done[1]}, 16'd0);
      drive(0, 0, 0, 0, 4'd1);
      step();
      chk("stop_term_done_after", {15'd0, o_done[1]}, 16'd0);

      // Start and stop in the same cycle while running
      drive(1, 0, 0, 1, 4'd6);
      repeat (2) step();
      drive(1, 1, 0, 1, 4'd6);
      step();
      chk("start_stop_busy", {15'd0, o_busy[0]}, 16'd0);
      chk("start_stop_paused", {15'd0, o_paused[2]}, 16'd0);

      // Terminal 0 one-shot with PRESCALE=3
      drive(1, 0, 0, 0, 4'd0);
      step();
      drive(0, 0, 0, 0, 4'd0);
      repeat (2) step();
      chk("t0_pre_done", {15'd0, o_done[2]}, 16'd0);
      step();
      chk("t0_done", {15'd0, o_done[2]}, 16'd1);
      chk("t0_cnt", {12'd0, o_cnt[2]}, 16'd0);
      step();
      chk("t0_done_pulse_end", {15'd0, o_done[2]}, 16'd0);

      // Terminal 15 periodic with PRESCALE=1: 15 then 0 with wrap
      drive(1, 0, 0, 1, 4'd15);
      step();
      drive(0, 0, 0, 0, 4'd0);
      repeat (15) step();
      chk("t15_cnt_max", {12'd0, o_cnt[0]}, 16'd15);
      step();
      chk("t15_cnt_wrap", {12'd0, o_cnt[0]}, 16'd0);
      chk("t15_wrap_pulse", {15'd0, o_wrap[0]}, 16'd1);

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         start = (r < 4) || (r == 6);
         stop  = (r >= 4 && r < 7);
         if ($urandom_range(0, 9) == 0) pause = ~pause;
         mode  = 1'($urandom_range(0, 1));
         term  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 4));
         step();
         if ($urandom_range(0, 499) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
